// File: rtl/ctrl_types_pkg.sv
// ctrl_types_pkg: shared types for the cache-controller command path.
//   op_e         : host opcode (GET/PUT/DEL, 3 is illegal)
//   main_state_e : top-level dispatcher states
package ctrl_types_pkg;

  localparam int unsigned OP_W = 2;
  localparam int unsigned ST_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_GET     = 2'd0,
    OP_PUT     = 2'd1,
    OP_DEL     = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_e;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_RUN      = 2'd2,
    ST_RESP     = 2'd3
  } main_state_e;

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// ctrl_timeout_cnt: RUN-phase watchdog counter for the dispatcher.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : zero the count (operation being dispatched)
//   inc_i      : count one RUN cycle
//   limit_i    : number of RUN cycles allowed
//   expired_c  : combinational, high on the counted cycle that reaches limit_i
module ctrl_timeout_cnt #(
  parameter int unsigned TO_W = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            inc_i,
  input  logic [TO_W-1:0] limit_i,
  output logic            expired_c
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // cnt_q holds completed RUN cycles, so this cycle is the limit-th one
  assign expired_c = inc_i && (cnt_q == TO_W'(limit_i - TO_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && !expired_c) begin
      cnt_d = TO_W'(cnt_q + TO_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ctrl_dispatch_fsm.sv
// ctrl_dispatch_fsm: top-level command dispatcher of the cache controller.
// Accepts one host request (valid/ready), pulses the selected GET/PUT/DEL
// sub-FSM enter, steps it with en until done, then holds one response until
// the host takes it. One operation in flight.
//   Host side : req_valid/req_ready/req_op, resp_valid/resp_ready,
//               resp_succ/resp_hit/resp_err/resp_timeout
//   Sub-FSMs  : x_enter/x_en out, x_done/x_succ in (x = get/put/del), get_rdy in
// All outputs are registered. Optional RUN watchdog: define CTRL_TIMEOUT_EN.
module ctrl_dispatch_fsm
  import ctrl_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  output logic            get_enter,
  output logic            get_en,
  input  logic            get_done,
  input  logic            get_succ,
  input  logic            get_rdy,
  output logic            put_enter,
  output logic            put_en,
  input  logic            put_done,
  input  logic            put_succ,
  output logic            del_enter,
  output logic            del_en,
  input  logic            del_done,
  input  logic            del_succ,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_succ,
  output logic            resp_hit,
  output logic            resp_err,
  output logic            resp_timeout
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("ctrl_dispatch_fsm: TIMEOUT_CYCLES must be at least 1");
  end

  main_state_e state_q, state_d;
  op_e         op_q, op_d;

  logic req_ready_q, req_ready_d;
  logic get_enter_q, get_enter_d, get_en_q, get_en_d;
  logic put_enter_q, put_enter_d, put_en_q, put_en_d;
  logic del_enter_q, del_enter_d, del_en_q, del_en_d;
  logic resp_valid_q, resp_valid_d;
  logic resp_succ_q, resp_succ_d;
  logic resp_hit_q, resp_hit_d;
  logic resp_err_q, resp_err_d;
  logic resp_timeout_q, resp_timeout_d;

  logic sel_done_c;
  logic sel_succ_c;

`ifdef CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic expired_c;

  ctrl_timeout_cnt #(.TO_W(TO_W)) u_timeout_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == ST_DISPATCH),
    .inc_i     (state_q == ST_RUN),
    .limit_i   (TO_W'(TIMEOUT_CYCLES)),
    .expired_c (expired_c)
  );
`endif

  // Only the selected sub-FSM's done/succ are visible to the FSM
  always_comb begin
    sel_done_c = 1'b0;
    sel_succ_c = 1'b0;
    case (op_q)
      OP_GET:  begin sel_done_c = get_done; sel_succ_c = get_succ; end
      OP_PUT:  begin sel_done_c = put_done; sel_succ_c = put_succ; end
      OP_DEL:  begin sel_done_c = del_done; sel_succ_c = del_succ; end
      default: begin sel_done_c = 1'b0;     sel_succ_c = 1'b0;     end
    endcase
  end

  // Next state, latched op/result, and output decode from the next state
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    resp_succ_d    = resp_succ_q;
    resp_hit_d     = resp_hit_q;
    resp_err_d     = resp_err_q;
    resp_timeout_d = resp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d = op_e'(req_op);
          if (op_e'(req_op) == OP_ILLEGAL) begin
            resp_err_d  = 1'b1;
            resp_succ_d = 1'b0;
            state_d     = ST_RESP;
          end else begin
            state_d = ST_DISPATCH;
          end
        end
      end
      ST_DISPATCH: state_d = ST_RUN;
      ST_RUN: begin
        if (sel_done_c) begin
          resp_succ_d = sel_succ_c;
          resp_hit_d  = (op_q == OP_GET) ? get_rdy : 1'b0;
          state_d     = ST_RESP;
        end
`ifdef CTRL_TIMEOUT_EN
        else if (expired_c) begin
          resp_timeout_d = 1'b1;
          resp_succ_d    = 1'b0;
          resp_hit_d     = 1'b0;
          state_d        = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (resp_ready) begin
          op_d           = OP_GET;
          resp_succ_d    = 1'b0;
          resp_hit_d     = 1'b0;
          resp_err_d     = 1'b0;
          resp_timeout_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    resp_valid_d = (state_d == ST_RESP);
    get_enter_d  = (state_d == ST_DISPATCH) && (op_d == OP_GET);
    put_enter_d  = (state_d == ST_DISPATCH) && (op_d == OP_PUT);
    del_enter_d  = (state_d == ST_DISPATCH) && (op_d == OP_DEL);
    get_en_d     = (state_d == ST_RUN) && (op_d == OP_GET);
    put_en_d     = (state_d == ST_RUN) && (op_d == OP_PUT);
    del_en_d     = (state_d == ST_RUN) && (op_d == OP_DEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_GET;
      req_ready_q    <= 1'b1;
      get_enter_q    <= 1'b0;
      get_en_q       <= 1'b0;
      put_enter_q    <= 1'b0;
      put_en_q       <= 1'b0;
      del_enter_q    <= 1'b0;
      del_en_q       <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_succ_q    <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      req_ready_q    <= req_ready_d;
      get_enter_q    <= get_enter_d;
      get_en_q       <= get_en_d;
      put_enter_q    <= put_enter_d;
      put_en_q       <= put_en_d;
      del_enter_q    <= del_enter_d;
      del_en_q       <= del_en_d;
      resp_valid_q   <= resp_valid_d;
      resp_succ_q    <= resp_succ_d;
      resp_hit_q     <= resp_hit_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign get_enter    = get_enter_q;
  assign get_en       = get_en_q;
  assign put_enter    = put_enter_q;
  assign put_en       = put_en_q;
  assign del_enter    = del_enter_q;
  assign del_en       = del_en_q;
  assign resp_valid   = resp_valid_q;
  assign resp_succ    = resp_succ_q;
  assign resp_hit     = resp_hit_q;
  assign resp_err     = resp_err_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_ctrl_dispatch_fsm.sv
// tb_ctrl_dispatch_fsm: directed self-checking bench for ctrl_dispatch_fsm.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Build with CTRL_TIMEOUT_EN defined to exercise the RUN watchdog (limit 8).
module tb_ctrl_dispatch_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op;
  logic       get_enter, get_en, get_done, get_succ, get_rdy;
  logic       put_enter, put_en, put_done, put_succ;
  logic       del_enter, del_en, del_done, del_succ;
  logic       resp_valid, resp_ready, resp_succ, resp_hit, resp_err, resp_timeout;

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_dispatch_fsm #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .get_enter(get_enter), .get_en(get_en), .get_done(get_done),
    .get_succ(get_succ), .get_rdy(get_rdy),
    .put_enter(put_enter), .put_en(put_en), .put_done(put_done), .put_succ(put_succ),
    .del_enter(del_enter), .del_en(del_en), .del_done(del_done), .del_succ(del_succ),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_succ(resp_succ),
    .resp_hit(resp_hit), .resp_err(resp_err), .resp_timeout(resp_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0; req_op = 2'd0; resp_ready = 1'b0;
    get_done = 1'b0; get_succ = 1'b0; get_rdy = 1'b0;
    put_done = 1'b0; put_succ = 1'b0;
    del_done = 1'b0; del_succ = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick(); tick();
    tests++;
    if ({req_ready, resp_valid, get_enter, get_en, put_enter, put_en, del_enter, del_en,
         resp_succ, resp_hit, resp_err, resp_timeout} !== 12'b1000_0000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b en/enter=%b%b%b%b%b%b resp=%b%b%b%b, want rdy=1 rest 0",
               req_ready, resp_valid, get_enter, get_en, put_enter, put_en, del_enter, del_en,
               resp_succ, resp_hit, resp_err, resp_timeout);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_get_latency();
    // cycle 0: request accepted
    req_valid = 1'b1; req_op = 2'd0;
    get_done = 1'b1; get_succ = 1'b1; get_rdy = 1'b1;
    tests++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL get_c0_ready: got %b want 1", req_ready); end
    tick(); req_valid = 1'b0;
    tests++;
    if ({get_enter, get_en, req_ready} !== 3'b100) begin
      errors++; $display("FAIL get_c1_enter: got enter/en/rdy=%b%b%b want 100", get_enter, get_en, req_ready);
    end
    tick();
    tests++;
    if ({get_enter, get_en, resp_valid} !== 3'b010) begin
      errors++; $display("FAIL get_c2_run: got enter/en/rv=%b%b%b want 010", get_enter, get_en, resp_valid);
    end
    tick(); get_done = 1'b0; resp_ready = 1'b1;
    tests++;
    if ({resp_valid, resp_succ, resp_hit, resp_err, resp_timeout, get_en} !== 6'b111000) begin
      errors++; $display("FAIL get_c3_resp: got v/s/h/e/t/en=%b%b%b%b%b%b want 111000",
                         resp_valid, resp_succ, resp_hit, resp_err, resp_timeout, get_en);
    end
    tick(); resp_ready = 1'b0;
    tests++;
    if ({resp_valid, req_ready, resp_succ, resp_hit} !== 4'b0100) begin
      errors++; $display("FAIL get_c4_idle: got v/rdy/s/h=%b%b%b%b want 0100", resp_valid, req_ready, resp_succ, resp_hit);
    end
    clear_inputs();
  endtask

  task automatic test_put_wait();
    int en_cnt = 0, enter_cnt = 0, other = 0, n = 0;
    // get_done/get_rdy held high to show unselected done and hit are ignored
    get_done = 1'b1; get_rdy = 1'b1; put_succ = 1'b0;
    req_valid = 1'b1; req_op = 2'd1;
    tick(); req_valid = 1'b0;
    while (!resp_valid && n < 40) begin
      if (put_en) en_cnt++;
      if (put_enter) enter_cnt++;
      if (get_enter || get_en || del_enter || del_en) other++;
      put_done = (en_cnt == 5);
      tick(); n++;
    end
    put_done = 1'b0;
    tests++;
    if (!resp_valid) begin errors++; $display("FAIL put_resp_timeout: no resp_valid after %0d cycles", n); end
    tests++;
    if (en_cnt !== 5) begin errors++; $display("FAIL put_en_cycles: got %0d want 5", en_cnt); end
    tests++;
    if (enter_cnt !== 1 || other !== 0) begin
      errors++; $display("FAIL put_isolation: got enter=%0d foreign=%0d want 1 and 0", enter_cnt, other);
    end
    tests++;
    if ({resp_succ, resp_hit, resp_err, resp_timeout, put_en} !== 5'b00000) begin
      errors++; $display("FAIL put_resp_fields: got s/h/e/t/en=%b%b%b%b%b want 00000",
                         resp_succ, resp_hit, resp_err, resp_timeout, put_en);
    end
    resp_ready = 1'b1; tick(); clear_inputs();
  endtask

  task automatic test_illegal_op();
    req_valid = 1'b1; req_op = 2'd3;
    tick(); req_valid = 1'b0;
    tests++;
    if ({resp_valid, resp_err, resp_succ, resp_timeout} !== 4'b1100) begin
      errors++; $display("FAIL illegal_resp: got v/e/s/t=%b%b%b%b want 1100", resp_valid, resp_err, resp_succ, resp_timeout);
    end
    tests++;
    if ({get_enter, get_en, put_enter, put_en, del_enter, del_en, req_ready} !== 7'b0) begin
      errors++; $display("FAIL illegal_no_enter: got %b%b%b%b%b%b rdy=%b want all 0",
                         get_enter, get_en, put_enter, put_en, del_enter, del_en, req_ready);
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    tests++;
    if ({resp_valid, resp_err, req_ready} !== 3'b001) begin
      errors++; $display("FAIL illegal_clear: got v/e/rdy=%b%b%b want 001", resp_valid, resp_err, req_ready);
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int n = 0;
    get_done = 1'b1; get_succ = 1'b1; get_rdy = 1'b0;
    req_valid = 1'b1; req_op = 2'd0;
    tick(); req_valid = 1'b0;
    while (!resp_valid && n < 10) begin tick(); n++; end
    get_done = 1'b0;
    // a competing PUT request is offered while the response is stalled
    req_valid = 1'b1; req_op = 2'd1;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({resp_valid, resp_succ, resp_hit, resp_err, req_ready, put_enter, put_en} !== 7'b1100000) begin
        errors++; $display("FAIL backpressure_hold[%0d]: got v/s/h/e/rdy/pe/pen=%b%b%b%b%b%b%b want 1100000", i,
                           resp_valid, resp_succ, resp_hit, resp_err, req_ready, put_enter, put_en);
      end
      tick();
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    tick(); resp_ready = 1'b0;
    tick();
    tests++;
    if ({req_ready, resp_valid, put_enter, put_en} !== 4'b1000) begin
      errors++; $display("FAIL backpressure_drop: got rdy/v/pe/pen=%b%b%b%b want 1000", req_ready, resp_valid, put_enter, put_en);
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] enter_trace = '0;
    get_done = 1'b1; get_succ = 1'b1; resp_ready = 1'b1;
    req_valid = 1'b1; req_op = 2'd0;
    for (int c = 0; c < 8; c++) begin
      enter_trace[c] = get_enter;
      tick();
    end
    req_valid = 1'b0;
    // accepts at cycle 0 and cycle 4, so enter pulses at cycles 1 and 5
    tests++;
    if (enter_trace !== 8'b0010_0010) begin
      errors++; $display("FAIL back_to_back_spacing: got enter trace %b want 00100010", enter_trace);
    end
    while (!req_ready || resp_valid) tick();
    clear_inputs();
  endtask

`ifdef CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int en_cnt = 0, n = 0;
    del_succ = 1'b1;
    req_valid = 1'b1; req_op = 2'd2;
    tick(); req_valid = 1'b0;
    while (!resp_valid && n < 40) begin
      if (del_en) en_cnt++;
      tick(); n++;
    end
    tests++;
    if (en_cnt !== 8 || !resp_valid) begin
      errors++; $display("FAIL timeout_cycles: got en=%0d v=%b want 8 and 1", en_cnt, resp_valid);
    end
    tests++;
    if ({resp_timeout, resp_succ, resp_hit, del_en} !== 4'b1000) begin
      errors++; $display("FAIL timeout_resp: got t/s/h/en=%b%b%b%b want 1000", resp_timeout, resp_succ, resp_hit, del_en);
    end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    // done on the same cycle the limit is hit: done wins
    en_cnt = 0; n = 0;
    req_valid = 1'b1; req_op = 2'd2;
    tick(); req_valid = 1'b0;
    while (!resp_valid && n < 40) begin
      if (del_en) en_cnt++;
      del_done = (en_cnt == 8);
      tick(); n++;
    end
    del_done = 1'b0;
    tests++;
    if ({resp_valid, resp_timeout, resp_succ} !== 3'b101 || en_cnt !== 8) begin
      errors++; $display("FAIL timeout_done_wins: got v/t/s=%b%b%b en=%0d want 101 and 8",
                         resp_valid, resp_timeout, resp_succ, en_cnt);
    end
    resp_ready = 1'b1; tick(); clear_inputs();
  endtask
`else
  task automatic test_no_timeout();
    int en_cnt = 0, n = 0;
    del_succ = 1'b1;
    req_valid = 1'b1; req_op = 2'd2;
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (del_en) en_cnt++;
      tick();
    end
    tests++;
    if ({del_en, resp_valid, resp_timeout} !== 3'b100 || en_cnt !== 20) begin
      errors++; $display("FAIL no_timeout_wait: got en/v/t=%b%b%b count=%0d want 100 and 20",
                         del_en, resp_valid, resp_timeout, en_cnt);
    end
    del_done = 1'b1;
    while (!resp_valid && n < 10) begin tick(); n++; end
    del_done = 1'b0;
    tests++;
    if ({resp_valid, resp_succ, resp_timeout, resp_hit} !== 4'b1100) begin
      errors++; $display("FAIL no_timeout_resp: got v/s/t/h=%b%b%b%b want 1100", resp_valid, resp_succ, resp_timeout, resp_hit);
    end
    resp_ready = 1'b1; tick(); clear_inputs();
  endtask
`endif

  task automatic test_reset_mid_run();
    int stale = 0;
    req_valid = 1'b1; req_op = 2'd0;
    tick(); req_valid = 1'b0;
    tick(); tick();
    tests++;
    if (get_en !== 1'b1) begin errors++; $display("FAIL rst_run_setup: got get_en=%b want 1", get_en); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, get_en, get_enter, resp_valid} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid_run: got rdy/en/enter/v=%b%b%b%b want 1000", req_ready, get_en, get_enter, resp_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    get_done = 1'b1; get_succ = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid || get_en || get_enter) stale++;
    end
    tests++;
    if (stale !== 0) begin errors++; $display("FAIL rst_no_stale: got %0d active cycles want 0", stale); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_get_latency();
    test_put_wait();
    test_illegal_op();
    test_backpressure();
    test_back_to_back();
`ifdef CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
